// File: rtl/cache_pkg.sv
// Cache-side types: memory arbiter grant states.
package cache_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } arb_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the machine word and the RAM status encoding.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/RAM bus seen by the memory arbiter; slave is the arbiter side,
// master is the caches plus RAM model side.
interface mem_arbiter_if #(parameter int RAM_ADDR_W = 32) ();
  logic                     dREN;
  logic                     dWEN;
  logic [RAM_ADDR_W-1:0]    daddr;
  cpu_types_pkg::word_t     dstore;
  logic                     dwait;
  cpu_types_pkg::word_t     dload;

  logic                     iREN;
  logic [RAM_ADDR_W-1:0]    iaddr;
  logic                     iwait;
  cpu_types_pkg::word_t     iload;

  logic                     ramREN;
  logic                     ramWEN;
  logic [RAM_ADDR_W-1:0]    ramaddr;
  cpu_types_pkg::word_t     ramstore;
  cpu_types_pkg::word_t     ramload;
  cpu_types_pkg::ramstate_t ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memarb_counter.sv
// 32-bit wrapping event counter, advances once per cycle while en is high.
module memarb_counter
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  en,
  output word_t count
);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      count <= '0;
    else if (en)
      count <= count + 32'd1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Dcache/icache to single-RAM-port arbiter, data has fixed priority; 1-cycle grant,
// completion in the first ACCESS cycle. MEMARB_STATS_EN adds dcount/icount.
module mem_arbiter
  import cpu_types_pkg::*;
  import cache_pkg::*;
(
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus,
  output logic         ram_err
`ifdef MEMARB_STATS_EN
  ,
  output word_t        dcount,
  output word_t        icount
`endif
);
  arb_state_t state;
  logic       d_req;
  logic       ram_acc;
  logic       d_done;
  logic       i_done;

  assign d_req   = bus.dREN | bus.dWEN;
  assign ram_acc = (bus.ramstate == ACCESS);
  assign d_done  = (state == DACC) && d_req && ram_acc;
  assign i_done  = (state == IACC) && bus.iREN && ram_acc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      ram_err <= 1'b0;
    end else begin
      if ((state != IDLE) && (bus.ramstate == ERROR))
        ram_err <= 1'b1;
      case (state)
        IDLE: begin
          if (d_req)
            state <= DACC;
          else if (bus.iREN)
            state <= IACC;
        end
        // A dropped request and a completed one both hand the port back.
        DACC:    if (!d_req || ram_acc) state <= IDLE;
        IACC:    if (!bus.iREN || ram_acc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    case (state)
      DACC: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (d_done) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end
      end
      IACC: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = bus.iREN;
        if (i_done) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

`ifdef MEMARB_STATS_EN
  memarb_counter u_dcount (.CLK(CLK), .nRST(nRST), .en(d_done), .count(dcount));
  memarb_counter u_icount (.CLK(CLK), .nRST(nRST), .en(i_done), .count(icount));
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable RAM model and
// per-cache scoreboards of expected load data.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  nRST;
  logic  ram_err;
`ifdef MEMARB_STATS_EN
  word_t dcount;
  word_t icount;
`endif

  mem_arbiter_if #(.RAM_ADDR_W(32)) bus ();

  mem_arbiter dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .bus     (bus),
    .ram_err (ram_err)
`ifdef MEMARB_STATS_EN
    ,
    .dcount  (dcount),
    .icount  (icount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int    n_cmp = 0;
  int    n_err = 0;
  word_t dq[$];
  word_t iq[$];

  // RAM model: BUSY until the strobe has been high for ram_lat cycles, then ACCESS.
  int    ram_lat = 3;
  int    ram_cnt = 0;
  logic  ram_err_inj = 1'b0;
  word_t rd_data = '0;
  word_t wr_addr = '0;
  word_t wr_data = '0;

  always @(posedge CLK) begin
    if (!(bus.ramREN || bus.ramWEN)) ram_cnt <= 0;
    else                             ram_cnt <= ram_cnt + 1;
    if (bus.ramWEN && bus.ramstate == ACCESS) begin
      wr_addr <= bus.ramaddr;
      wr_data <= bus.ramstore;
    end
  end

  always_comb begin
    if (ram_err_inj)                       bus.ramstate = ERROR;
    else if (!(bus.ramREN || bus.ramWEN))  bus.ramstate = FREE;
    else if (ram_cnt >= ram_lat - 1)       bus.ramstate = ACCESS;
    else                                   bus.ramstate = BUSY;
  end
  assign bus.ramload = rd_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Completion monitor: each wait pulse pops one expected load word.
  always @(negedge CLK) begin
    if (nRST) begin
      if (bus.dwait === 1'b0) begin
        n_cmp++;
        assert (dq.size() != 0) else begin
          n_err++;
          $error("FAIL d_unexpected: observed completion with empty scoreboard, required none");
        end
        if (dq.size() != 0) chk("dload", bus.dload, dq.pop_front());
      end else begin
        chk("dload_hidden", bus.dload, 32'h0);
      end
      if (bus.iwait === 1'b0) begin
        n_cmp++;
        assert (iq.size() != 0) else begin
          n_err++;
          $error("FAIL i_unexpected: observed completion with empty scoreboard, required none");
        end
        if (iq.size() != 0) chk("iload", bus.iload, iq.pop_front());
      end else begin
        chk("iload_hidden", bus.iload, 32'h0);
      end
    end
  end

  // Called in an IDLE cycle; returns the cycle offset at which wait dropped, or -1.
  task automatic wait_done(input bit is_d, input int budget, output int took);
    took = -1;
    for (int k = 0; k <= budget; k++) begin
      @(negedge CLK);
      if ((is_d ? bus.dwait : bus.iwait) === 1'b0) begin
        took = k;
        break;
      end
      step();
    end
  endtask

  task automatic do_access(input bit is_d, input word_t addr, input word_t data, input int lat);
    int took;
    ram_lat = lat;
    rd_data = data;
    if (is_d) begin
      bus.dREN = 1'b1; bus.daddr = addr; dq.push_back(data);
    end else begin
      bus.iREN = 1'b1; bus.iaddr = addr; iq.push_back(data);
    end
    wait_done(is_d, lat + 4, took);
    chk(is_d ? "d_latency" : "i_latency", took, lat);
    step();
    if (is_d) bus.dREN = 1'b0;
    else      bus.iREN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.iREN = 1'b0; bus.iaddr = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ctrl", 32'({bus.dwait, bus.iwait, bus.ramREN, bus.ramWEN, ram_err}), 32'b11000);
    chk("rst_addr", bus.ramaddr, 32'h0);
    chk("rst_store", bus.ramstore, 32'h0);
    step(); nRST = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk("idle_ctrl", 32'({bus.dwait, bus.iwait, bus.ramREN, bus.ramWEN, ram_err}), 32'b11000);
    end

    // Dcache read, RAM latency 3
    step();
    ram_lat = 3; rd_data = 32'hDEADBEEF;
    bus.dREN = 1'b1; bus.daddr = 32'h40; dq.push_back(32'hDEADBEEF);
    @(negedge CLK);
    chk("rd_c0_strobe", 32'(bus.ramREN), 32'h0);
    for (int c = 1; c <= 3; c++) begin
      step(); @(negedge CLK);
      chk("rd_dwait", 32'(bus.dwait), 32'(c != 3));
      chk("rd_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'b10);
      chk("rd_addr", bus.ramaddr, 32'h40);
    end
    step(); bus.dREN = 1'b0;
    @(negedge CLK);
    chk("rd_after", 32'({bus.dwait, bus.ramREN}), 32'b10);

    // Simultaneous dWEN and iREN: write first
    step();
    ram_lat = 3; rd_data = 32'h0BAD0001;
    bus.dWEN = 1'b1; bus.daddr = 32'h3100; bus.dstore = 32'h12345678;
    bus.iREN = 1'b1; bus.iaddr = 32'h200; dq.push_back(32'h0BAD0001);
    @(negedge CLK);
    chk("wr_c0_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'b00);
    for (int c = 1; c <= 3; c++) begin
      step(); @(negedge CLK);
      chk("wr_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'b01);
      chk("wr_addr", bus.ramaddr, 32'h3100);
      chk("wr_data", bus.ramstore, 32'h12345678);
      chk("wr_waits", 32'({bus.dwait, bus.iwait}), 32'({c != 3, 1'b1}));
    end

    // Back-to-back dcache word still beats the pending iREN
    step();
    bus.dWEN = 1'b0; bus.dREN = 1'b1; bus.daddr = 32'h3104;
    ram_lat = 2; rd_data = 32'h0BAD0002; dq.push_back(32'h0BAD0002);
    @(negedge CLK);
    chk("b2b_idle", 32'({bus.ramREN, bus.ramWEN, bus.dwait, bus.iwait}), 32'b0011);
    for (int c = 1; c <= 2; c++) begin
      step(); @(negedge CLK);
      chk("b2b_addr", bus.ramaddr, 32'h3104);
      chk("b2b_ctrl", 32'({bus.ramREN, bus.dwait, bus.iwait}), 32'({1'b1, c != 2, 1'b1}));
    end
    step();
    bus.dREN = 1'b0; ram_lat = 3; rd_data = 32'h1CE00200; iq.push_back(32'h1CE00200);
    @(negedge CLK);
    chk("i_idle", 32'({bus.ramREN, bus.ramWEN, bus.iwait}), 32'b001);
    for (int c = 1; c <= 3; c++) begin
      step(); @(negedge CLK);
      chk("i_addr", bus.ramaddr, 32'h200);
      chk("i_ctrl", 32'({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}), 32'({2'b10, c != 3, 1'b1}));
    end
    step(); bus.iREN = 1'b0;
    chk("wr_cap_addr", wr_addr, 32'h3100);
    chk("wr_cap_data", wr_data, 32'h12345678);

    // Withdrawn dcache read while RAM is BUSY
    bus.dREN = 1'b1; bus.daddr = 32'h44; ram_lat = 20;
    step(); @(negedge CLK);
    chk("wd_grant", 32'({bus.ramREN, bus.dwait}), 32'b11);
    step(); bus.dREN = 1'b0;
    @(negedge CLK);
    chk("wd_drop", 32'({bus.ramREN, bus.ramWEN, bus.dwait}), 32'b001);
    step();
    ram_lat = 2; rd_data = 32'h5A5A0500;
    bus.iREN = 1'b1; bus.iaddr = 32'h500; iq.push_back(32'h5A5A0500);
    step(); @(negedge CLK);
    chk("wd_then_i_addr", bus.ramaddr, 32'h500);
    chk("wd_then_i_ren", 32'(bus.ramREN), 32'h1);
    step(); @(negedge CLK);
    chk("wd_then_i_done", 32'(bus.iwait), 32'h0);
    step(); bus.iREN = 1'b0;
`ifdef MEMARB_STATS_EN
    chk("wd_dcount", dcount, 32'd3);
    chk("wd_icount", icount, 32'd2);
`endif

    // RAM ERROR during an icache access, then reset
    ram_lat = 50; bus.iREN = 1'b1; bus.iaddr = 32'h600;
    step(); ram_err_inj = 1'b1;
    @(negedge CLK);
    chk("err_c1", 32'({ram_err, bus.iwait, bus.ramREN}), 32'b011);
    step(); @(negedge CLK);
    chk("err_set", 32'({ram_err, bus.iwait, bus.ramREN}), 32'b111);
    step(); ram_err_inj = 1'b0;
    @(negedge CLK);
    chk("err_sticky", 32'({ram_err, bus.iwait, bus.ramREN}), 32'b111);
    step(); nRST = 1'b0;
    @(negedge CLK);
    chk("err_rst", 32'({ram_err, bus.iwait, bus.ramREN}), 32'b010);
    step(); bus.iREN = 1'b0; nRST = 1'b1;
    @(negedge CLK);
    chk("err_post", 32'({ram_err, bus.iwait, bus.ramREN, bus.ramWEN}), 32'b0100);

    // Completion runs with mixed latencies
    step();
    for (int n = 0; n < 5; n++)
      do_access(1'b1, 32'h1000 + 32'(n * 4), 32'hD0000000 + 32'(n), 1 + (n % 3));
    for (int n = 0; n < 3; n++)
      do_access(1'b0, 32'h2000 + 32'(n * 4), 32'hE0000000 + 32'(n), 2 + n);
`ifdef MEMARB_STATS_EN
    chk("dcount", dcount, 32'd5);
    chk("icount", icount, 32'd3);
    force dut.u_dcount.count = 32'hFFFFFFFF;
    step();
    release dut.u_dcount.count;
    do_access(1'b1, 32'h1100, 32'hD00000FF, 2);
    chk("dcount_wrap", dcount, 32'd0);
    chk("icount_hold", icount, 32'd3);
`endif

    step();
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
